control_fsm: RTL and testbench

//  Multi-cycle RV32I control unit for BEAN-1; drives every datapath control input.

---
 rtl/control_fsm_if.sv | 9 +
 rtl/control_fsm.sv | 232 +++++++++++++++++++++++
 tb/tb_control_fsm.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_fsm_if.sv
// control_fsm_if: request/ready handshake between the BEAN-1 control unit and unified memory.
interface control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I control unit for BEAN-1 (RST/FETCH/DECODE/EXEC/MEM/HALT).
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal encodings with a sticky illegal flag.
module control_fsm #(
  parameter int unsigned RESET_STALL = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instr,
  input  logic          jump,
  control_fsm_if.master mem,
  output logic          reg_WE,
  output logic          rs1_SEL,
  output logic          rs2_SEL,
  output logic          addrs_SEL,
  output logic          pc_EN,
  output logic          instr_EN,
  output logic          ALU_mem_EN,
  output logic          mem_in_EN,
  output logic [1:0]    reg_SEL,
  output logic [1:0]    pc_SEL,
  output logic [2:0]    imm_SEL,
  output logic [3:0]    ALU_MODE,
  output logic          instr_done,
  output logic          illegal
);

  localparam int unsigned CW = $clog2(RESET_STALL + 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] stall_cnt;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic          bad;
  logic          trap;
  logic          is_mem;
  logic [3:0]    alu_rr;
  logic [3:0]    alu_br;
  logic          req;
  logic          we;
  logic          unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign mem.mem_req = req;
  assign mem.mem_we  = we;

  always_comb begin
    bad = 1'b0;
    case (opcode)
      OPC_OP:    bad = !(funct7 == 7'b0000000 ||
                         (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      OPC_OPIMM: begin
        if (funct3 == 3'b001)      bad = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101) bad = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
      end
      // funct3 010/011 are reserved branch encodings
      OPC_BRANCH: bad = (funct3 == 3'b010) || (funct3 == 3'b011);
      OPC_LOAD, OPC_STORE: bad = (funct3 != 3'b010);
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_FENCE, OPC_SYSTEM: bad = 1'b0;
      default: bad = 1'b1;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trap = bad;
`else
  assign trap = 1'b0;
`endif

  assign is_mem = !bad && (opcode == OPC_LOAD || opcode == OPC_STORE);

  // instr[30] selects SUB only for register-register ops; in OP-IMM funct3=000 it is immediate data
  assign alu_rr = {((funct3 == 3'b000) && (opcode == OPC_OP) && instr[30]) ||
                   ((funct3 == 3'b101) && instr[30]), funct3};

  always_comb begin
    alu_br = 4'b0000;
    case (funct3)
      3'b000:  alu_br = 4'b1001;
      3'b001:  alu_br = 4'b1010;
      3'b100:  alu_br = 4'b0010;
      3'b101:  alu_br = 4'b1011;
      3'b110:  alu_br = 4'b0011;
      3'b111:  alu_br = 4'b1100;
      default: alu_br = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_RST;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= (state == S_RST) ? stall_cnt + CW'(1) : '0;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      illegal_q <= 1'b0;
    else if (state == S_EXEC && bad) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:    if (stall_cnt == CW'(RESET_STALL)) state_nxt = S_FETCH;
      S_FETCH:  if (mem.mem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (trap)        state_nxt = S_HALT;
        else if (is_mem) state_nxt = S_MEM;
        else             state_nxt = S_FETCH;
      end
      S_MEM:    if (mem.mem_ready) state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_RST;
    endcase
  end

  always_comb begin
    req        = 1'b0;
    we         = 1'b0;
    reg_WE     = 1'b0;
    rs1_SEL    = 1'b0;
    rs2_SEL    = 1'b0;
    addrs_SEL  = 1'b0;
    pc_EN      = 1'b0;
    instr_EN   = 1'b0;
    ALU_mem_EN = 1'b0;
    mem_in_EN  = 1'b0;
    reg_SEL    = 2'd0;
    pc_SEL     = 2'd0;
    imm_SEL    = 3'd0;
    ALU_MODE   = 4'b0000;
    case (state)
      S_FETCH: begin
        req       = 1'b1;
        addrs_SEL = 1'b1;
        mem_in_EN = 1'b1;
        instr_EN  = mem.mem_ready;
      end
      S_EXEC: begin
        if (trap) begin
          pc_EN = 1'b0;
        end else if (bad) begin
          pc_EN = 1'b1;
        end else begin
          case (opcode)
            OPC_OP: begin
              ALU_MODE = alu_rr; reg_SEL = 2'd1; reg_WE = 1'b1; pc_EN = 1'b1;
            end
            OPC_OPIMM: begin
              rs2_SEL = 1'b1; ALU_MODE = alu_rr; reg_SEL = 2'd1; reg_WE = 1'b1; pc_EN = 1'b1;
            end
            OPC_LUI: begin
              imm_SEL = 3'd3; reg_SEL = 2'd2; reg_WE = 1'b1; pc_EN = 1'b1;
            end
            OPC_AUIPC: begin
              rs1_SEL = 1'b1; rs2_SEL = 1'b1; imm_SEL = 3'd3;
              reg_SEL = 2'd1; reg_WE = 1'b1; pc_EN = 1'b1;
            end
            OPC_JAL: begin
              imm_SEL = 3'd4; reg_SEL = 2'd3; reg_WE = 1'b1; pc_SEL = 2'd2; pc_EN = 1'b1;
            end
            OPC_JALR: begin
              rs2_SEL = 1'b1; reg_SEL = 2'd3; reg_WE = 1'b1; pc_SEL = 2'd1; pc_EN = 1'b1;
            end
            OPC_BRANCH: begin
              imm_SEL = 3'd2; ALU_MODE = alu_br; pc_SEL = jump ? 2'd2 : 2'd0; pc_EN = 1'b1;
            end
            // address rs1+imm is already formed here so it is settled when MEM issues
            OPC_LOAD:  rs2_SEL = 1'b1;
            OPC_STORE: begin
              rs2_SEL = 1'b1; imm_SEL = 3'd1;
            end
            default: pc_EN = 1'b1;
          endcase
        end
      end
      S_MEM: begin
        req     = 1'b1;
        rs2_SEL = 1'b1;
        if (opcode == OPC_STORE) begin
          we         = 1'b1;
          ALU_mem_EN = 1'b1;
          imm_SEL    = 3'd1;
        end else begin
          mem_in_EN = 1'b1;
          reg_SEL   = 2'd0;
          reg_WE    = mem.mem_ready;
        end
        pc_EN = mem.mem_ready;
      end
      default: req = 1'b0;
    endcase
    instr_done = pc_EN;
  end

  // store data and load data share the memory bus
  a_no_bus_contention: assert property (@(posedge clk) disable iff (!reset)
                                        !(ALU_mem_EN && mem_in_EN));

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: table-driven and randomized instruction-level checks of control_fsm.
`timescale 1ns/1ps
module tb_control_fsm;

  localparam int unsigned RESET_STALL = 1;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b1000, A_SLL = 4'b0001, A_SLT = 4'b0010,
                         A_SLTU = 4'b0011, A_XOR = 4'b0100, A_SRL = 4'b0101, A_SRA = 4'b1101,
                         A_OR = 4'b0110, A_AND = 4'b0111, A_EQ = 4'b1001, A_NE = 4'b1010,
                         A_GE = 4'b1011, A_GEU = 4'b1100;

  typedef struct packed {
    logic       mem_req, mem_we, reg_WE, rs1_SEL, rs2_SEL, addrs_SEL, pc_EN, instr_EN;
    logic       ALU_mem_EN, mem_in_EN;
    logic [1:0] reg_SEL, pc_SEL;
    logic [2:0] imm_SEL;
    logic [3:0] ALU_MODE;
    logic       instr_done, illegal;
  } ctl_t;

  typedef enum {K_OP, K_OPI, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_NOP, K_BAD} kind_t;

  typedef struct {
    logic [31:0] ins;
    logic        jmp;
    int          fw;
    int          mw;
    ctl_t        exp_exec;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        jump;
  logic        reg_WE, rs1_SEL, rs2_SEL, addrs_SEL, pc_EN, instr_EN, ALU_mem_EN, mem_in_EN;
  logic [1:0]  reg_SEL, pc_SEL;
  logic [2:0]  imm_SEL;
  logic [3:0]  ALU_MODE;
  logic        instr_done, illegal;

  int n_checks = 0;
  int n_fail = 0;
  int exp_retired = 0;
  int obs_retired = 0;

  control_fsm_if mif ();

  control_fsm #(.RESET_STALL(RESET_STALL)) dut (
    .clk(clk), .reset(reset), .instr(instr), .jump(jump), .mem(mif),
    .reg_WE(reg_WE), .rs1_SEL(rs1_SEL), .rs2_SEL(rs2_SEL), .addrs_SEL(addrs_SEL),
    .pc_EN(pc_EN), .instr_EN(instr_EN), .ALU_mem_EN(ALU_mem_EN), .mem_in_EN(mem_in_EN),
    .reg_SEL(reg_SEL), .pc_SEL(pc_SEL), .imm_SEL(imm_SEL), .ALU_MODE(ALU_MODE),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (instr_done) obs_retired <= obs_retired + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t outs();
    ctl_t o;
    o.mem_req = mif.mem_req;  o.mem_we = mif.mem_we;  o.reg_WE = reg_WE;
    o.rs1_SEL = rs1_SEL;      o.rs2_SEL = rs2_SEL;    o.addrs_SEL = addrs_SEL;
    o.pc_EN = pc_EN;          o.instr_EN = instr_EN;  o.ALU_mem_EN = ALU_mem_EN;
    o.mem_in_EN = mem_in_EN;  o.reg_SEL = reg_SEL;    o.pc_SEL = pc_SEL;
    o.imm_SEL = imm_SEL;      o.ALU_MODE = ALU_MODE;  o.instr_done = instr_done;
    o.illegal = illegal;
    return o;
  endfunction

  // EXEC-cycle vector from register-file/immediate/ALU/writeback/pc choices
  function automatic ctl_t ex(input logic r1, input logic r2, input logic [2:0] imm,
                              input logic [3:0] alu, input logic [1:0] rsel, input logic we,
                              input logic [1:0] psel, input logic pen);
    ctl_t o = '0;
    o.rs1_SEL = r1; o.rs2_SEL = r2; o.imm_SEL = imm; o.ALU_MODE = alu;
    o.reg_SEL = rsel; o.reg_WE = we; o.pc_SEL = psel; o.pc_EN = pen; o.instr_done = pen;
    return o;
  endfunction

  function automatic ctl_t exp_fetch(input logic rdy);
    ctl_t o = '0;
    o.mem_req = 1'b1; o.addrs_SEL = 1'b1; o.mem_in_EN = 1'b1; o.instr_EN = rdy;
    return o;
  endfunction

  function automatic kind_t classify(input logic [31:0] ins);
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    case (ins[6:0])
      7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? K_OP : K_BAD;
      7'h13: begin
        if (f3 == 3'd1 && f7 != 7'h00) return K_BAD;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return K_BAD;
        return K_OPI;
      end
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      7'h6F: return K_JAL;
      7'h67: return K_JALR;
      7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? K_BAD : K_BR;
      7'h03: return (f3 == 3'd2) ? K_LD : K_BAD;
      7'h23: return (f3 == 3'd2) ? K_ST : K_BAD;
      7'h0F, 7'h73: return K_NOP;
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [31:0] ins, input kind_t k);
    if (k == K_BR) begin
      case (ins[14:12])
        3'd0: return A_EQ;   3'd1: return A_NE;  3'd4: return A_SLT;
        3'd5: return A_GE;   3'd6: return A_SLTU; default: return A_GEU;
      endcase
    end
    case (ins[14:12])
      3'd0: return (k == K_OP && ins[30]) ? A_SUB : A_ADD;
      3'd1: return A_SLL;
      3'd2: return A_SLT;
      3'd3: return A_SLTU;
      3'd4: return A_XOR;
      3'd5: return ins[30] ? A_SRA : A_SRL;
      3'd6: return A_OR;
      default: return A_AND;
    endcase
  endfunction

  function automatic ctl_t model_exec(input logic [31:0] ins, input logic jmp);
    kind_t k = classify(ins);
    case (k)
      K_OP:    return ex(0, 0, 3'd0, alu_of(ins, k), 2'd1, 1, 2'd0, 1);
      K_OPI:   return ex(0, 1, 3'd0, alu_of(ins, k), 2'd1, 1, 2'd0, 1);
      K_LUI:   return ex(0, 0, 3'd3, A_ADD, 2'd2, 1, 2'd0, 1);
      K_AUIPC: return ex(1, 1, 3'd3, A_ADD, 2'd1, 1, 2'd0, 1);
      K_JAL:   return ex(0, 0, 3'd4, A_ADD, 2'd3, 1, 2'd2, 1);
      K_JALR:  return ex(0, 1, 3'd0, A_ADD, 2'd3, 1, 2'd1, 1);
      K_BR:    return ex(0, 0, 3'd2, alu_of(ins, k), 2'd0, 0, jmp ? 2'd2 : 2'd0, 1);
      K_LD:    return ex(0, 1, 3'd0, A_ADD, 2'd0, 0, 2'd0, 0);
      K_ST:    return ex(0, 1, 3'd1, A_ADD, 2'd0, 0, 2'd0, 0);
      K_NOP:   return ex(0, 0, 3'd0, A_ADD, 2'd0, 0, 2'd0, 1);
      default: return TRAP ? ctl_t'('0) : ex(0, 0, 3'd0, A_ADD, 2'd0, 0, 2'd0, 1);
    endcase
  endfunction

  function automatic ctl_t model_mem(input logic [31:0] ins, input logic rdy);
    ctl_t o = '0;
    o.mem_req = 1'b1; o.rs2_SEL = 1'b1; o.pc_EN = rdy; o.instr_done = rdy;
    if (classify(ins) == K_ST) begin
      o.mem_we = 1'b1; o.ALU_mem_EN = 1'b1; o.imm_SEL = 3'd1;
    end else begin
      o.mem_in_EN = 1'b1; o.reg_WE = rdy;
    end
    return o;
  endfunction

  task automatic check(input string name, input ctl_t exp);
    ctl_t act = outs();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s instr=%h: got %h required %h", name, instr, act, exp);
    end
  endtask

  task automatic settle(input logic rdy, input logic jmp);
    mif.mem_ready = rdy;
    jump = jmp;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_async_zero", '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int unsigned i = 0; i <= RESET_STALL; i++) begin
      settle(1'b1, 1'b0);
      check("rst_stall", '0);
      advance();
    end
    settle(1'b0, 1'b0);
    check("rst_to_fetch", exp_fetch(1'b0));
    advance();
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [31:0] ins, input logic jmp, input int fw, input int mw,
                           input ctl_t exp_ex);
    kind_t k = classify(ins);
    instr = ins;
    for (int i = 0; i < fw; i++) begin
      settle(1'b0, rbit());
      check("fetch_wait", exp_fetch(1'b0));
      advance();
    end
    settle(1'b1, rbit());
    check("fetch_ready", exp_fetch(1'b1));
    advance();
    settle(rbit(), rbit());
    check("decode", '0);
    advance();
    settle(rbit(), jmp);
    check("exec", exp_ex);
    advance();
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i < mw; i++) begin
        settle(1'b0, rbit());
        check("mem_wait", model_mem(ins, 1'b0));
        advance();
      end
      settle(1'b1, rbit());
      check("mem_ready", model_mem(ins, 1'b1));
      advance();
      exp_retired++;
    end else if (k == K_BAD && TRAP) begin
      for (int i = 0; i < 3; i++) begin
        ctl_t h = '0;
        h.illegal = 1'b1;
        instr = $urandom;
        settle(rbit(), rbit());
        check("halt", h);
        advance();
      end
      do_reset();
    end else begin
      exp_retired++;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    if ($urandom_range(0, 4) == 0) return r;
    case ($urandom_range(0, 10))
      0: r[6:0] = 7'h33;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h37;  3: r[6:0] = 7'h17;
      4: r[6:0] = 7'h6F;  5: r[6:0] = 7'h67;  6: r[6:0] = 7'h63;  7: r[6:0] = 7'h03;
      8: r[6:0] = 7'h23;  9: r[6:0] = 7'h0F;  default: r[6:0] = 7'h73;
    endcase
    if ($urandom_range(0, 3) != 0) r[31:25] = rbit() ? 7'h20 : 7'h00;
    if ((r[6:0] == 7'h03 || r[6:0] == 7'h23) && $urandom_range(0, 3) != 0) r[14:12] = 3'b010;
    return r;
  endfunction

  initial begin
    vec_t tbl[$];
    ctl_t nop_bad;
    int   base_retired;
    nop_bad = TRAP ? ctl_t'('0) : ex(0, 0, 3'd0, A_ADD, 2'd0, 0, 2'd0, 1);

    reset = 1'b0; instr = '0; jump = 1'b0; mif.mem_ready = 1'b0;
    #2;
    check("power_on_zero", '0);
    do_reset();

    // asynchronous reset in the middle of an outstanding fetch
    settle(1'b0, 1'b0);
    check("pre_reset_fetch", exp_fetch(1'b0));
    do_reset();

    base_retired = obs_retired;
    tbl.push_back('{32'h00500093, 0, 0, 0, ex(0, 1, 3'd0, A_ADD,  2'd1, 1, 2'd0, 1)});
    tbl.push_back('{32'h002081B3, 0, 1, 0, ex(0, 0, 3'd0, A_ADD,  2'd1, 1, 2'd0, 1)});
    tbl.push_back('{32'h402081B3, 0, 0, 0, ex(0, 0, 3'd0, A_SUB,  2'd1, 1, 2'd0, 1)});
    tbl.push_back('{32'h40008093, 0, 0, 0, ex(0, 1, 3'd0, A_ADD,  2'd1, 1, 2'd0, 1)});
    tbl.push_back('{32'h4020D193, 0, 0, 0, ex(0, 1, 3'd0, A_SRA,  2'd1, 1, 2'd0, 1)});
    tbl.push_back('{32'h0020D1B3, 0, 0, 0, ex(0, 0, 3'd0, A_SRL,  2'd1, 1, 2'd0, 1)});
    tbl.push_back('{32'h0020B1B3, 0, 0, 0, ex(0, 0, 3'd0, A_SLTU, 2'd1, 1, 2'd0, 1)});
    tbl.push_back('{32'h0020F1B3, 0, 0, 0, ex(0, 0, 3'd0, A_AND,  2'd1, 1, 2'd0, 1)});
    tbl.push_back('{32'h123452B7, 0, 0, 0, ex(0, 0, 3'd3, A_ADD,  2'd2, 1, 2'd0, 1)});
    tbl.push_back('{32'h00001297, 0, 0, 0, ex(1, 1, 3'd3, A_ADD,  2'd1, 1, 2'd0, 1)});
    tbl.push_back('{32'h010000EF, 0, 0, 0, ex(0, 0, 3'd4, A_ADD,  2'd3, 1, 2'd2, 1)});
    tbl.push_back('{32'h000080E7, 0, 0, 0, ex(0, 1, 3'd0, A_ADD,  2'd3, 1, 2'd1, 1)});
    tbl.push_back('{32'h00000463, 1, 0, 0, ex(0, 0, 3'd2, A_EQ,   2'd0, 0, 2'd2, 1)});
    tbl.push_back('{32'h00000463, 0, 0, 0, ex(0, 0, 3'd2, A_EQ,   2'd0, 0, 2'd0, 1)});
    tbl.push_back('{32'h00209463, 1, 0, 0, ex(0, 0, 3'd2, A_NE,   2'd0, 0, 2'd2, 1)});
    tbl.push_back('{32'h0020C463, 0, 0, 0, ex(0, 0, 3'd2, A_SLT,  2'd0, 0, 2'd0, 1)});
    tbl.push_back('{32'h0020F463, 1, 0, 0, ex(0, 0, 3'd2, A_GEU,  2'd0, 0, 2'd2, 1)});
    tbl.push_back('{32'h0FF0000F, 0, 0, 0, ex(0, 0, 3'd0, A_ADD,  2'd0, 0, 2'd0, 1)});
    tbl.push_back('{32'h00000073, 0, 0, 0, ex(0, 0, 3'd0, A_ADD,  2'd0, 0, 2'd0, 1)});
    tbl.push_back('{32'h0000A103, 0, 0, 3, ex(0, 1, 3'd0, A_ADD,  2'd0, 0, 2'd0, 0)});
    tbl.push_back('{32'h0020A223, 0, 0, 1, ex(0, 1, 3'd1, A_ADD,  2'd0, 0, 2'd0, 0)});
    tbl.push_back('{32'h00008103, 0, 0, 0, nop_bad});
    tbl.push_back('{32'h022081B3, 0, 0, 0, nop_bad});
    tbl.push_back('{32'hFFFFFFFF, 0, 0, 0, nop_bad});
    foreach (tbl[i]) run_instr(tbl[i].ins, tbl[i].jmp, tbl[i].fw, tbl[i].mw, tbl[i].exp_exec);

    for (int n = 0; n < 250; n++) begin
      logic [31:0] ri = rand_instr();
      logic        rj = rbit();
      run_instr(ri, rj, $urandom_range(0, 2), $urandom_range(0, 3), model_exec(ri, rj));
    end

    @(posedge clk);
    #1;
    n_checks++;
    if (obs_retired - base_retired != exp_retired) begin
      n_fail++;
      $display("FAIL retired_count: got %0d required %0d", obs_retired - base_retired, exp_retired);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
